// File: rtl/seg_check_arbiter.sv
// seg_check_arbiter: arbitrates three requesters onto one segment limit checker and latches faults.
// Define SEG_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed stack > op0 > op1.
module seg_check_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req_valid,
    output logic [2:0]  req_ready,
    input  logic [95:0] req_addr,
    input  logic [8:0]  req_seg,
    input  logic [8:0]  req_size,
    output logic [31:0] chk_address,
    output logic        chk_address_is_valid,
    output logic [2:0]  chk_segment,
    output logic [2:0]  chk_size,
    input  logic        chk_exception,
    output logic [2:0]  resp_valid,
    output logic        resp_fault,
    input  logic        flush,
    input  logic        exc_clear,
    output logic        exc_pending,
    output logic [1:0]  exc_src,
    output logic [31:0] exc_address
);
    typedef enum logic [1:0] {IDLE, CHECK, FAULT} state_t;
    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, exc_addr_q, exc_addr_d, win_addr;
    logic [2:0]  seg_q, seg_d, size_q, size_d, win_seg, win_size;
    logic [1:0]  src_q, src_d, exc_src_q, exc_src_d, win;
    logic        exc_pending_q, exc_pending_d, can_grant, xfer, live;
`ifdef SEG_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d, c1, c2;
    always_comb begin
        c1 = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
        c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
        win = req_valid[ptr_q] ? ptr_q : req_valid[c1] ? c1 : c2;
        ptr_d = xfer ? ((win == 2'd2) ? 2'd0 : win + 2'd1) : ptr_q;
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) ptr_q <= 2'd0;
        else ptr_q <= ptr_d;
`else
    assign win = req_valid[2] ? 2'd2 : req_valid[0] ? 2'd0 : 2'd1;
`endif
    assign win_addr = (win == 2'd2) ? req_addr[95:64] : (win == 2'd1) ? req_addr[63:32] : req_addr[31:0];
    assign win_seg  = (win == 2'd2) ? req_seg[8:6] : (win == 2'd1) ? req_seg[5:3] : req_seg[2:0];
    assign win_size = (win == 2'd2) ? req_size[8:6] : (win == 2'd1) ? req_size[5:3] : req_size[2:0];
    // A faulting check blocks the back-to-back grant so the fault is taken first.
    assign can_grant = !reset && !flush && (state_q == IDLE || (state_q == CHECK && !chk_exception));
    assign req_ready = (can_grant && |req_valid) ? 3'b001 << win : 3'b000;
    assign xfer = |req_ready;
    assign live = (state_q == CHECK) && !flush;
    assign resp_valid = live ? 3'b001 << src_q : 3'b000;
    assign resp_fault = live && chk_exception;
    assign chk_address = addr_q;
    assign chk_segment = seg_q;
    assign chk_size = size_q;
    assign chk_address_is_valid = (state_q == CHECK);
    assign exc_pending = exc_pending_q;
    assign exc_src = exc_src_q;
    assign exc_address = exc_addr_q;
    always_comb begin
        state_d = state_q;
        addr_d = xfer ? win_addr : addr_q;
        seg_d = xfer ? win_seg : seg_q;
        size_d = xfer ? win_size : size_q;
        src_d = xfer ? win : src_q;
        exc_pending_d = exc_pending_q;
        exc_src_d = exc_src_q;
        exc_addr_d = exc_addr_q;
        if (flush) begin
            state_d = IDLE;
            exc_pending_d = 1'b0;
        end else if (state_q == FAULT) begin
            if (exc_clear) begin
                state_d = IDLE;
                exc_pending_d = 1'b0;
            end
        end else if (state_q == CHECK && chk_exception) begin
            state_d = FAULT;
            exc_pending_d = 1'b1;
            exc_src_d = src_q;
            exc_addr_d = addr_q;
        end else begin
            state_d = xfer ? CHECK : IDLE;
        end
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            addr_q <= '0;
            seg_q <= '0;
            size_q <= '0;
            src_q <= '0;
            exc_pending_q <= 1'b0;
            exc_src_q <= '0;
            exc_addr_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            seg_q <= seg_d;
            size_q <= size_d;
            src_q <= src_d;
            exc_pending_q <= exc_pending_d;
            exc_src_q <= exc_src_d;
            exc_addr_q <= exc_addr_d;
        end
endmodule
